// File: rtl/demux_sel_sequencer_if.sv
// rtl/demux_sel_sequencer_if.sv - control/status bundle for the demux select sequencer
interface demux_sel_sequencer_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 en;
  logic [1:0]           mode;
  logic [3:0]           ch_mask;
  logic [DIV_WIDTH-1:0] dwell;
  logic                 start;
  logic [1:0]           sel;
  logic                 tick;
  logic                 active;
  logic                 busy;
  logic                 done;

  modport master (
    output en, mode, ch_mask, dwell, start,
    input  sel, tick, active, busy, done
  );

  modport slave (
    input  en, mode, ch_mask, dwell, start,
    output sel, tick, active, busy, done
  );
endinterface

// File: rtl/demux_sel_sequencer.sv
// rtl/demux_sel_sequencer.sv - channel select sequencer for the 1:4 clock demux
module demux_sel_sequencer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  demux_sel_sequencer_if.slave        bus_if
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_SCAN  = 2'b00;
  localparam logic [1:0] MODE_SWEEP = 2'b10;

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tick_q, tick_d;

  logic [DIV_WIDTH-1:0] dwell_m1;
  logic                 dwell_last;
  logic                 mask_any;
  logic [1:0]           first_ch;
  logic [1:0]           wrap_ch;
  logic [2:0]           up_ch;

  function automatic logic [1:0] first_set(input logic [3:0] m);
    first_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) first_set = 2'(i);
    end
  endfunction

  // Smallest forward offset wins; offset 4 lands back on s for a lone channel.
  function automatic logic [1:0] next_wrap(input logic [1:0] s, input logic [3:0] m);
    next_wrap = s;
    for (int k = 4; k >= 1; k--) begin
      if (m[s + 2'(k)]) next_wrap = s + 2'(k);
    end
  endfunction

  // {found, index} of the lowest enabled channel strictly above s.
  function automatic logic [2:0] next_up(input logic [1:0] s, input logic [3:0] m);
    next_up = {1'b0, s};
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(s))) next_up = {1'b1, 2'(i)};
    end
  endfunction

  assign dwell_m1   = (bus_if.dwell == '0) ? '0 : bus_if.dwell - DIV_WIDTH'(1);
  assign dwell_last = (cnt_q >= dwell_m1);
  assign mask_any   = (bus_if.ch_mask != 4'b0000);
  assign first_ch   = first_set(bus_if.ch_mask);
  assign wrap_ch    = next_wrap(sel_q, bus_if.ch_mask);
  assign up_ch      = next_up(sel_q, bus_if.ch_mask);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus_if.en && mask_any) begin
          if (bus_if.mode == MODE_SCAN) begin
            state_d = S_SCAN;
            sel_d   = first_ch;
            tick_d  = 1'b1;
          end else if ((bus_if.mode == MODE_SWEEP) && bus_if.start) begin
            state_d = S_SWEEP;
            sel_d   = first_ch;
            tick_d  = 1'b1;
          end
        end
      end

      S_SCAN: begin
        if (!bus_if.en || (bus_if.mode == MODE_SWEEP) || !mask_any) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (bus_if.mode == MODE_SCAN) begin
          if (dwell_last) begin
            cnt_d  = '0;
            sel_d  = wrap_ch;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
          end
        end
      end

      S_SWEEP: begin
        if (!bus_if.en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (dwell_last) begin
          cnt_d = '0;
          if (up_ch[2]) begin
            sel_d  = up_ch[1:0];
            tick_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus_if.sel    = sel_q;
  assign bus_if.tick   = tick_q;
  assign bus_if.active = (state_q == S_SCAN) || (state_q == S_SWEEP);
  assign bus_if.busy   = (state_q == S_SWEEP);
  assign bus_if.done   = (state_q == S_DONE);

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// tb/tb_demux_sel_sequencer.sv - directed bench for demux_sel_sequencer
module tb_demux_sel_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  demux_sel_sequencer_if #(.DIV_WIDTH(16)) bus_if ();

  demux_sel_sequencer #(.DIV_WIDTH(16)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector layout: {sel[1:0], tick, active, busy, done}
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {bus_if.sel, bus_if.tick, bus_if.active, bus_if.busy, bus_if.done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed sel/tick/active/busy/done=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [1:0] s, input logic t,
                     input logic a, input logic b, input logic d);
    @(negedge clk);
    chk(tag, {s, t, a, b, d});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_if.en      = 1'b0;
    bus_if.mode    = 2'b00;
    bus_if.ch_mask = 4'b0000;
    bus_if.dwell   = 16'd0;
    bus_if.start   = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset", 6'b00_0000);
    rst = 1'b0;

    // empty mask never leaves IDLE
    bus_if.en = 1'b1;
    bus_if.dwell = 16'd1;
    repeat (3) cyc("mask0_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // full scan, dwell 3
    bus_if.ch_mask = 4'b1111;
    bus_if.dwell = 16'd3;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc("scan4", 2'(k % 4), (j == 0), 1'b1, 1'b0, 1'b0);
      end
    end
    bus_if.en = 1'b0;
    cyc("scan_stop", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // masked channels skipped, dwell 1
    bus_if.ch_mask = 4'b1010;
    bus_if.dwell = 16'd1;
    bus_if.en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc("skip", (k % 2 == 1) ? 2'd3 : 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    bus_if.en = 1'b0;
    cyc("skip_stop", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // dwell 0 behaves as dwell 1
    bus_if.ch_mask = 4'b1111;
    bus_if.dwell = 16'd0;
    bus_if.en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc("dwell0", 2'(k % 4), 1'b1, 1'b1, 1'b0, 1'b0);
    end
    bus_if.en = 1'b0;
    cyc("dwell0_stop", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // one-shot sweep over channels 1,2 with dwell 2; start while busy ignored
    bus_if.en = 1'b1;
    bus_if.mode = 2'b10;
    bus_if.ch_mask = 4'b0110;
    bus_if.dwell = 16'd2;
    bus_if.start = 1'b1;
    cyc("sw_a0", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    bus_if.start = 1'b0;
    cyc("sw_a1", 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    bus_if.start = 1'b1;
    cyc("sw_b0", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    bus_if.start = 1'b0;
    cyc("sw_b1", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("sw_done", 2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("sw_idle", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("sw_idle2", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // sweep aborted by en=0: no done
    bus_if.ch_mask = 4'b1111;
    bus_if.dwell = 16'd4;
    bus_if.start = 1'b1;
    cyc("ab0", 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    bus_if.start = 1'b0;
    cyc("ab1", 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    bus_if.en = 1'b0;
    cyc("ab_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc("ab_nodone", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // pause mid-dwell, then resume with remaining dwell
    bus_if.en = 1'b1;
    bus_if.mode = 2'b00;
    cyc("ps0", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("ps1", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus_if.mode = 2'b01;
    repeat (5) cyc("pause01", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus_if.mode = 2'b00;
    cyc("resume2", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("resume3", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("resume_adv", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_if.mode = 2'b11;
    repeat (2) cyc("pause11", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus_if.mode = 2'b00;
    bus_if.dwell = 16'd1;
    cyc("dwell_shrink", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_if.ch_mask = 4'b0000;
    cyc("mask0_scan", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // mask cleared mid-sweep ends at next expiry
    bus_if.ch_mask = 4'b1111;
    bus_if.dwell = 16'd2;
    bus_if.mode = 2'b10;
    bus_if.start = 1'b1;
    cyc("swm0", 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    bus_if.start = 1'b0;
    bus_if.ch_mask = 4'b0000;
    cyc("swm1", 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("swm_done", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("swm_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-scan overrides
    bus_if.mode = 2'b00;
    bus_if.ch_mask = 4'b1000;
    bus_if.dwell = 16'd5;
    cyc("pre_rst", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("post_rst", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
